// File: rtl/operand_unit_scheduler.sv
// Round-robin scheduler time-sharing one combinational operand unit between two requesters.
// Holds registered operands for SETTLE cycles, then captures the unit result with a done pulse.
module operand_unit_scheduler #(
    parameter int unsigned OP_W   = 3,
    parameter int unsigned RES_W  = 8,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [OP_W-1:0]  a0,
    input  logic [OP_W-1:0]  b0,
    input  logic             req1,
    input  logic [OP_W-1:0]  a1,
    input  logic [OP_W-1:0]  b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [RES_W-1:0] res_o,
    output logic [OP_W-1:0]  unit_a,
    output logic [OP_W-1:0]  unit_b,
    input  logic [RES_W-1:0] unit_res,
    output logic             busy,
    output logic [7:0]       op_cnt
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state, state_next;
    logic               ptr, ptr_next;
    logic               owner, owner_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               gnt0_next, gnt1_next, done0_next, done1_next, busy_next;
    logic [RES_W-1:0]   res_next;
    logic [OP_W-1:0]    a_next, b_next;
    logic [7:0]         op_cnt_next;
    logic               sel1;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            owner  <= 1'b0;
            cnt    <= '0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            res_o  <= '0;
            unit_a <= '0;
            unit_b <= '0;
            busy   <= 1'b0;
            op_cnt <= '0;
        end else begin
            state  <= state_next;
            ptr    <= ptr_next;
            owner  <= owner_next;
            cnt    <= cnt_next;
            gnt0   <= gnt0_next;
            gnt1   <= gnt1_next;
            done0  <= done0_next;
            done1  <= done1_next;
            res_o  <= res_next;
            unit_a <= a_next;
            unit_b <= b_next;
            busy   <= busy_next;
            op_cnt <= op_cnt_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next  = state;
        ptr_next    = ptr;
        owner_next  = owner;
        cnt_next    = cnt;
        gnt0_next   = 1'b0;
        gnt1_next   = 1'b0;
        done0_next  = 1'b0;
        done1_next  = 1'b0;
        res_next    = res_o;
        a_next      = unit_a;
        b_next      = unit_b;
        op_cnt_next = op_cnt;
        sel1        = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // ptr high means requester 0 was granted last
                    sel1       = req1 && (!req0 || ptr);
                    owner_next = sel1;
                    ptr_next   = !sel1;
                    a_next     = sel1 ? a1 : a0;
                    b_next     = sel1 ? b1 : b0;
                    gnt0_next  = !sel1;
                    gnt1_next  = sel1;
                    cnt_next   = CNT_W'(SETTLE - 1);
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    res_next    = unit_res;
                    done0_next  = !owner;
                    done1_next  = owner;
                    op_cnt_next = op_cnt + 8'd1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next == HOLD);
    end

endmodule

// File: tb/tb_operand_unit_scheduler.sv
// Directed bench for operand_unit_scheduler: one instance with SETTLE=1, one with SETTLE=3,
// each driving a modelled adder unit (unit_res = unit_a + unit_b, zero-extended).
module tb_operand_unit_scheduler;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // SETTLE=1 instance signals
    logic       s1_req0, s1_req1, s1_gnt0, s1_gnt1, s1_done0, s1_done1, s1_busy;
    logic [2:0] s1_a0, s1_b0, s1_a1, s1_b1, s1_unit_a, s1_unit_b;
    logic [7:0] s1_res_o, s1_unit_res, s1_op_cnt;

    // SETTLE=3 instance signals
    logic       s3_req0, s3_req1, s3_gnt0, s3_gnt1, s3_done0, s3_done1, s3_busy;
    logic [2:0] s3_a0, s3_b0, s3_a1, s3_b1, s3_unit_a, s3_unit_b;
    logic [7:0] s3_res_o, s3_unit_res, s3_op_cnt;

    assign s1_unit_res = 8'(s1_unit_a) + 8'(s1_unit_b);
    assign s3_unit_res = 8'(s3_unit_a) + 8'(s3_unit_b);

    operand_unit_scheduler #(.OP_W(3), .RES_W(8), .SETTLE(1)) u_s1 (
        .clk(clk), .reset(reset),
        .req0(s1_req0), .a0(s1_a0), .b0(s1_b0),
        .req1(s1_req1), .a1(s1_a1), .b1(s1_b1),
        .gnt0(s1_gnt0), .gnt1(s1_gnt1), .done0(s1_done0), .done1(s1_done1),
        .res_o(s1_res_o), .unit_a(s1_unit_a), .unit_b(s1_unit_b),
        .unit_res(s1_unit_res), .busy(s1_busy), .op_cnt(s1_op_cnt)
    );

    operand_unit_scheduler #(.OP_W(3), .RES_W(8), .SETTLE(3)) u_s3 (
        .clk(clk), .reset(reset),
        .req0(s3_req0), .a0(s3_a0), .b0(s3_b0),
        .req1(s3_req1), .a1(s3_a1), .b1(s3_b1),
        .gnt0(s3_gnt0), .gnt1(s3_gnt1), .done0(s3_done0), .done1(s3_done1),
        .res_o(s3_res_o), .unit_a(s3_unit_a), .unit_b(s3_unit_b),
        .unit_res(s3_unit_res), .busy(s3_busy), .op_cnt(s3_op_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and settle just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero_s1(input string tag);
        check({tag, ".gnt0"},   32'(s1_gnt0),   0);
        check({tag, ".gnt1"},   32'(s1_gnt1),   0);
        check({tag, ".done0"},  32'(s1_done0),  0);
        check({tag, ".done1"},  32'(s1_done1),  0);
        check({tag, ".res_o"},  32'(s1_res_o),  0);
        check({tag, ".unit_a"}, 32'(s1_unit_a), 0);
        check({tag, ".unit_b"}, 32'(s1_unit_b), 0);
        check({tag, ".busy"},   32'(s1_busy),   0);
        check({tag, ".op_cnt"}, 32'(s1_op_cnt), 0);
    endtask

    initial begin
        logic [2:0] ta, tb;
        reset = 1'b1;
        s1_req0 = 0; s1_req1 = 0; s1_a0 = 0; s1_b0 = 0; s1_a1 = 0; s1_b1 = 0;
        s3_req0 = 0; s3_req1 = 0; s3_a0 = 0; s3_b0 = 0; s3_a1 = 0; s3_b1 = 0;

        // 1. reset held two cycles
        step();
        step();
        check_all_zero_s1("rst");
        check("rst.s3_busy",   32'(s3_busy),   0);
        check("rst.s3_op_cnt", 32'(s3_op_cnt), 0);

        // 2. single op on requester 0, SETTLE=1
        reset = 1'b0;
        s1_req0 = 1; s1_a0 = 3'd3; s1_b0 = 3'd4;
        step();
        check("t2.gnt0",   32'(s1_gnt0),   1);
        check("t2.unit_a", 32'(s1_unit_a), 3);
        check("t2.unit_b", 32'(s1_unit_b), 4);
        check("t2.busy1",  32'(s1_busy),   1);
        check("t2.done0a", 32'(s1_done0),  0);
        s1_req0 = 0;
        step();
        check("t2.done0",  32'(s1_done0),  1);
        check("t2.gnt0b",  32'(s1_gnt0),   0);
        check("t2.res_o",  32'(s1_res_o),  7);
        check("t2.op_cnt", 32'(s1_op_cnt), 1);
        check("t2.busy2",  32'(s1_busy),   0);
        step();
        check("t2.done0c", 32'(s1_done0),  0);
        check("t2.hold",   32'(s1_res_o),  7);

        // 3. both requesters high from reset release: alternating grants
        reset = 1'b1;
        step();
        reset = 1'b0;
        s1_req0 = 1; s1_a0 = 3'd1; s1_b0 = 3'd2;
        s1_req1 = 1; s1_a1 = 3'd5; s1_b1 = 3'd6;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("t3.gnt0[%0d]", k),  32'(s1_gnt0),  (k % 2 == 0) ? 1 : 0);
            check($sformatf("t3.gnt1[%0d]", k),  32'(s1_gnt1),  (k % 2 == 1) ? 1 : 0);
            check($sformatf("t3.gdone[%0d]", k), 32'({s1_done0, s1_done1}), 0);
            step();
            check($sformatf("t3.done0[%0d]", k), 32'(s1_done0), (k % 2 == 0) ? 1 : 0);
            check($sformatf("t3.done1[%0d]", k), 32'(s1_done1), (k % 2 == 1) ? 1 : 0);
            check($sformatf("t3.dgnt[%0d]", k),  32'({s1_gnt0, s1_gnt1}), 0);
            check($sformatf("t3.res_o[%0d]", k), 32'(s1_res_o), (k % 2 == 0) ? 3 : 11);
        end
        s1_req0 = 0; s1_req1 = 0;
        check("t3.op_cnt", 32'(s1_op_cnt), 4);

        // 4. SETTLE=3 on requester 1
        s3_req1 = 1; s3_a1 = 3'd7; s3_b1 = 3'd7;
        step();
        check("t4.gnt1",   32'(s3_gnt1), 1);
        check("t4.gnt0",   32'(s3_gnt0), 0);
        check("t4.busy1",  32'(s3_busy), 1);
        s3_req1 = 0;
        step();
        check("t4.busy2",  32'(s3_busy),  1);
        check("t4.gnt1b",  32'(s3_gnt1),  0);
        check("t4.done2",  32'(s3_done1), 0);
        step();
        check("t4.busy3",  32'(s3_busy),  1);
        check("t4.done3",  32'(s3_done1), 0);
        step();
        check("t4.done1",  32'(s3_done1), 1);
        check("t4.done0",  32'(s3_done0), 0);
        check("t4.res_o",  32'(s3_res_o), 14);
        check("t4.busy4",  32'(s3_busy),  0);
        check("t4.op_cnt", 32'(s3_op_cnt), 1);

        // 5. reset during HOLD aborts the op
        s1_req0 = 1; s1_a0 = 3'd2; s1_b0 = 3'd2;
        step();
        check("t5.gnt0", 32'(s1_gnt0), 1);
        s1_req0 = 0;
        reset = 1'b1;
        step();
        check_all_zero_s1("t5.rst");
        reset = 1'b0;
        s1_req1 = 1; s1_a1 = 3'd1; s1_b1 = 3'd1;
        step();
        check("t5.gnt1",   32'(s1_gnt1), 1);
        check("t5.gnt0b",  32'(s1_gnt0), 0);
        s1_req1 = 0;
        step();
        check("t5.done1",  32'(s1_done1),  1);
        check("t5.res_o",  32'(s1_res_o),  2);
        check("t5.op_cnt", 32'(s1_op_cnt), 1);

        // 6. 256 single ops: op_cnt wraps to zero
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ta = 3'(i);
            tb = 3'(i >> 3);
            s1_req0 = 1; s1_a0 = ta; s1_b0 = tb;
            step();
            s1_req0 = 0;
            step();
            check($sformatf("t6.done0[%0d]", i),  32'(s1_done0),  1);
            check($sformatf("t6.res_o[%0d]", i),  32'(s1_res_o),  32'(ta) + 32'(tb));
            check($sformatf("t6.op_cnt[%0d]", i), 32'(s1_op_cnt), (i + 1) % 256);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
